// File: rtl/udp_tx_builder.sv
// udp_tx_builder: builds one UDP datagram (8-byte header + payload) from an
// application byte stream and hands it to the IP TX layer over valid/ready.
// Optional feature macro: UDP_TX_LEN_CHECK_EN (check app_eof against tx_len).
module udp_tx_builder #(
  parameter logic [15:0] SRC_PORT    = 16'h4321,
  parameter logic [15:0] DEST_PORT   = 16'h1234,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [15:0] tx_len,
  output logic        tx_busy,
  input  logic [7:0]  app_data_in,
  input  logic        app_byte_valid,
  input  logic        app_eof,
  output logic        app_ready,
  output logic [7:0]  udp_data_out,
  output logic        udp_byte_valid,
  input  logic        ip_ready,
  output logic        udp_eof,
  output logic        udp_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [15:0] len, len_nx;
  logic [15:0] rem, rem_nx;
  logic [2:0]  hdr_cnt, hdr_cnt_nx;
  logic [7:0]  data_nx;
  logic        valid_nx, eof_nx, err_nx, busy_nx;
  logic        load, accept;

  // Header byte for slot idx; the length field covers header plus payload.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] plen);
    logic [15:0] total;
    total = plen + 16'd8;
    case (idx)
      3'd0:    hdr_byte = SRC_PORT[15:8];
      3'd1:    hdr_byte = SRC_PORT[7:0];
      3'd2:    hdr_byte = DEST_PORT[15:8];
      3'd3:    hdr_byte = DEST_PORT[7:0];
      3'd4:    hdr_byte = total[15:8];
      3'd5:    hdr_byte = total[7:0];
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  // Next-state, output-register next values and handshake decode.
  always_comb begin
    state_nx   = state;
    len_nx     = len;
    rem_nx     = rem;
    hdr_cnt_nx = hdr_cnt;
    data_nx    = udp_data_out;
    valid_nx   = udp_byte_valid;
    eof_nx     = udp_eof;
    err_nx     = udp_err;
    busy_nx    = tx_busy;

    // Output slot is free when empty or being consumed this cycle.
    load      = !udp_byte_valid || ip_ready;
    app_ready = ((state == S_PAYLOAD) && (rem != 16'd0) && load) || (state == S_FLUSH);
    accept    = app_byte_valid && app_ready;

    if (udp_byte_valid && ip_ready && udp_eof)
      busy_nx = 1'b0;

    if (load) begin
      valid_nx = 1'b0;
      eof_nx   = 1'b0;
      err_nx   = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (tx_start && !tx_busy && load) begin
          if (tx_len <= MAX_PAYLOAD) begin
            // Header byte 0 is loaded on the accepting edge.
            len_nx     = tx_len;
            data_nx    = hdr_byte(3'd0, tx_len);
            valid_nx   = 1'b1;
            hdr_cnt_nx = 3'd1;
            busy_nx    = 1'b1;
            state_nx   = S_HEADER;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      S_HEADER: begin
        if (load) begin
          data_nx    = hdr_byte(hdr_cnt, len);
          valid_nx   = 1'b1;
          hdr_cnt_nx = hdr_cnt + 3'd1;
          if (hdr_cnt == 3'd7) begin
            if (len == 16'd0) begin
              eof_nx   = 1'b1;
              state_nx = S_IDLE;
            end else begin
              rem_nx   = len;
              state_nx = S_PAYLOAD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          data_nx  = app_data_in;
          valid_nx = 1'b1;
          rem_nx   = rem - 16'd1;
          if (rem == 16'd1) begin
            eof_nx   = 1'b1;
            state_nx = S_IDLE;
`ifdef UDP_TX_LEN_CHECK_EN
            if (!app_eof) begin
              err_nx   = 1'b1;
              state_nx = S_FLUSH;
            end
`endif
          end
`ifdef UDP_TX_LEN_CHECK_EN
          else if (app_eof) begin
            // Application ended early: short datagram flagged as errored.
            eof_nx   = 1'b1;
            err_nx   = 1'b1;
            rem_nx   = 16'd0;
            state_nx = S_IDLE;
          end
`endif
        end
      end
      S_FLUSH: begin
        // Discard surplus application bytes through its eof.
        if (app_byte_valid && app_eof)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      len            <= 16'd0;
      rem            <= 16'd0;
      hdr_cnt        <= 3'd0;
      udp_data_out   <= 8'h00;
      udp_byte_valid <= 1'b0;
      udp_eof        <= 1'b0;
      udp_err        <= 1'b0;
      tx_busy        <= 1'b0;
    end else begin
      state          <= state_nx;
      len            <= len_nx;
      rem            <= rem_nx;
      hdr_cnt        <= hdr_cnt_nx;
      udp_data_out   <= data_nx;
      udp_byte_valid <= valid_nx;
      udp_eof        <= eof_nx;
      udp_err        <= err_nx;
      tx_busy        <= busy_nx;
    end
  end

endmodule

// File: tb/tb_udp_tx_builder.sv
// tb_udp_tx_builder: directed bench for udp_tx_builder with hand-computed datagrams.
module tb_udp_tx_builder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_start;
  logic [15:0] tx_len;
  logic        tx_busy;
  logic [7:0]  app_data_in;
  logic        app_byte_valid;
  logic        app_eof;
  logic        app_ready;
  logic [7:0]  udp_data_out;
  logic        udp_byte_valid;
  logic        ip_ready;
  logic        udp_eof;
  logic        udp_err;

  int total = 0;
  int bad   = 0;

  logic [9:0] obs_q[$];   // {eof, err, data} of each accepted output byte
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  int         eof_idx;
  bit         tgl = 1'b0;
  int         err_pulses = 0;
  int         hold_viol  = 0;
  int         stall_rdy  = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d     = 8'h00;

  udp_tx_builder dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_len(tx_len), .tx_busy(tx_busy),
    .app_data_in(app_data_in), .app_byte_valid(app_byte_valid), .app_eof(app_eof),
    .app_ready(app_ready), .udp_data_out(udp_data_out), .udp_byte_valid(udp_byte_valid),
    .ip_ready(ip_ready), .udp_eof(udp_eof), .udp_err(udp_err)
  );

  always #5 clk = ~clk;

  // Observe the output side mid-cycle.
  always @(negedge clk) begin
    if (udp_byte_valid && ip_ready) obs_q.push_back({udp_eof, udp_err, udp_data_out});
    if (udp_err && !udp_byte_valid) err_pulses++;
    if (prev_stall && (!udp_byte_valid || udp_data_out != prev_d)) hold_viol++;
    if (udp_byte_valid && !ip_ready && app_ready) stall_rdy++;
    prev_stall = udp_byte_valid && !ip_ready;
    prev_d     = udp_data_out;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tgl) ip_ready = ~ip_ready;
  endtask

  task automatic start(input logic [15:0] l);
    tx_start = 1'b1;
    tx_len   = l;
    step();
    tx_start = 1'b0;
  endtask

  // Offer src_q bytes to the builder; app_eof marks index eof_idx.
  task automatic send();
    int  i = 0;
    int  cyc = 0;
    bit  acc;
    while (i < src_q.size() && cyc < 300) begin
      app_byte_valid = 1'b1;
      app_data_in    = src_q[i];
      app_eof        = (i == eof_idx);
      @(negedge clk);
      acc = app_ready;
      step();
      if (acc) i++;
      cyc++;
    end
    app_byte_valid = 1'b0;
    app_eof        = 1'b0;
    if (i < src_q.size()) chk("send_timeout", i, src_q.size());
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (tx_busy && cyc < 300) begin
      step();
      cyc++;
    end
    chk({tag, "_idle"}, tx_busy, 1'b0);
    step();
  endtask

  task automatic cmp(input string tag, input bit err_last);
    int last;
    last = exp_q.size() - 1;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), obs_q[i],
          {(i == last), (i == last) && err_last, exp_q[i]});
  endtask

  initial begin
    rst_n = 1'b0; tx_start = 1'b0; tx_len = 16'd0;
    app_data_in = 8'h00; app_byte_valid = 1'b0; app_eof = 1'b0; ip_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", udp_byte_valid, 1'b0);
    chk("rst_eof",   udp_eof, 1'b0);
    chk("rst_err",   udp_err, 1'b0);
    chk("rst_busy",  tx_busy, 1'b0);
    chk("rst_data",  udp_data_out, 8'h00);
    chk("rst_ardy",  app_ready, 1'b0);
    rst_n = 1'b1;
    step();

    // 1: four-byte payload, ip always ready
    obs_q.delete();
    start(16'd4);
    @(negedge clk);
    chk("t1_first_valid", udp_byte_valid, 1'b1);
    chk("t1_first_data",  udp_data_out, 8'h43);
    step();
    src_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; eof_idx = 3;
    send();
    wait_idle("t1");
    exp_q = '{8'h43, 8'h21, 8'h12, 8'h34, 8'h00, 8'h0C, 8'h00, 8'h00,
              8'hDE, 8'hAD, 8'hBE, 8'hEF};
    cmp("t1", 1'b0);

    // 2: empty payload
    obs_q.delete();
    start(16'd0);
    wait_idle("t2");
    exp_q = '{8'h43, 8'h21, 8'h12, 8'h34, 8'h00, 8'h08, 8'h00, 8'h00};
    cmp("t2", 1'b0);
    chk("t2_busy_after", tx_busy, 1'b0);

    // 3: oversize request rejected
    obs_q.delete();
    err_pulses = 0;
    start(16'd1473);
    @(negedge clk);
    chk("t3_busy", tx_busy, 1'b0);
    repeat (4) step();
    chk("t3_err_pulses", err_pulses, 1);
    chk("t3_no_bytes", obs_q.size(), 0);
    chk("t3_busy_end", tx_busy, 1'b0);

    // 4: ip_ready toggling every cycle
    obs_q.delete();
    hold_viol = 0;
    stall_rdy = 0;
    tgl = 1'b1;
    start(16'd3);
    src_q = '{8'h11, 8'h22, 8'h33}; eof_idx = 2;
    send();
    wait_idle("t4");
    tgl = 1'b0;
    ip_ready = 1'b1;
    step();
    exp_q = '{8'h43, 8'h21, 8'h12, 8'h34, 8'h00, 8'h0B, 8'h00, 8'h00,
              8'h11, 8'h22, 8'h33};
    cmp("t4", 1'b0);
    chk("t4_hold", hold_viol, 0);
    chk("t4_stall_ready", stall_rdy, 0);

    // 5: early app_eof on payload byte 2 of 5
    obs_q.delete();
    start(16'd5);
    src_q = '{8'hAA, 8'hBB}; eof_idx = 1;
    send();
`ifdef UDP_TX_LEN_CHECK_EN
    wait_idle("t5");
    exp_q = '{8'h43, 8'h21, 8'h12, 8'h34, 8'h00, 8'h0D, 8'h00, 8'h00,
              8'hAA, 8'hBB};
    cmp("t5", 1'b1);
`else
    repeat (3) step();
    chk("t5_still_busy", tx_busy, 1'b1);
    chk("t5_partial", obs_q.size(), 10);
    src_q = '{8'hCC, 8'hDD, 8'hEE}; eof_idx = 2;
    send();
    wait_idle("t5");
    exp_q = '{8'h43, 8'h21, 8'h12, 8'h34, 8'h00, 8'h0D, 8'h00, 8'h00,
              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    cmp("t5", 1'b0);
`endif

    // 6: reset mid-header, then a fresh one-byte datagram
    obs_q.delete();
    start(16'd4);
    for (int c = 0; c < 50 && obs_q.size() < 3; c++) step();
    chk("t6_reached_hdr3", obs_q.size(), 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", udp_byte_valid, 1'b0);
    chk("t6_rst_eof",   udp_eof, 1'b0);
    chk("t6_rst_busy",  tx_busy, 1'b0);
    chk("t6_rst_data",  udp_data_out, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    obs_q.delete();
    start(16'd1);
    src_q = '{8'h5A}; eof_idx = 0;
    send();
    wait_idle("t6");
    exp_q = '{8'h43, 8'h21, 8'h12, 8'h34, 8'h00, 8'h09, 8'h00, 8'h00, 8'h5A};
    cmp("t6", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
